// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture and generator blocks: register
// addresses, CTRL/STATUS bit positions, FSM state codes and a STATUS packer.
package pwm_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_HIGH   = 2'd3;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_CLR_BIT   = 1;

  localparam int STAT_VALID_BIT = 0;
  localparam int STAT_OVF_BIT   = 1;
  localparam int STAT_LEVEL_BIT = 2;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_RISE = 2'd1;
  localparam logic [1:0] ST_MEASURE   = 2'd2;

  // Packs the three status flags into a 32-bit word with unused bits at zero.
  function automatic logic [31:0] statusWord(input logic valid, input logic ovf,
                                             input logic level);
    logic [31:0] w;
    w                 = '0;
    w[STAT_VALID_BIT] = valid;
    w[STAT_OVF_BIT]   = ovf;
    w[STAT_LEVEL_BIT] = level;
    return w;
  endfunction

endpackage

// File: rtl/avalon_pwm_capture_if.sv
// Avalon-MM slave bus bundle for the PWM capture block.
interface avalon_pwm_capture_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic        read_n;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata, read_n,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata, read_n,
    output readdata
  );
endinterface

// File: rtl/pwm_edge_sync.sv
// Brings the asynchronous PWM input into the clk domain and produces
// single-cycle rising/falling edge pulses plus the synchronized level.
module pwm_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Synchronizer chain followed by one register holding the previous level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/avalon_pwm_capture.sv
// PWM period / high-time capture with an Avalon-MM register interface.
// Measures rise-to-rise period and high time of pwm_in in clk cycles.
module avalon_pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  avalon_pwm_capture_if.slave bus,
  input  logic                pwm_in
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             w_level, w_rise, w_fall;
  logic             w_wr, w_rd, w_ctrlWr, w_enNext, w_clr;
  logic             w_sat, w_measuring, w_load, w_ovfEvt;
  logic [31:0]      w_ctrlWord;
  logic             w_unused;

  logic [1:0]       r_state;
  logic             r_en;
  logic [CNT_W-1:0] r_cnt, r_hcnt, r_period, r_high;
  logic             r_valid, r_ovf;
  logic [31:0]      r_readdata;

  pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edgeSync (
    .clk     (clk),
    .reset   (reset),
    .i_async (pwm_in),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // A disable written this cycle already stops the FSM at this edge, so
  // measurement decisions use the post-write enable value.
  assign w_wr        = bus.chipselect & ~bus.write_n;
  assign w_rd        = bus.chipselect & ~bus.read_n;
  assign w_ctrlWr    = w_wr && (bus.address == ADDR_CTRL);
  assign w_enNext    = w_ctrlWr ? bus.writedata[CTRL_EN_BIT] : r_en;
  assign w_clr       = w_ctrlWr && bus.writedata[CTRL_CLR_BIT];
  assign w_sat       = (r_cnt == CNT_MAX);
  assign w_measuring = (r_state == ST_MEASURE) && w_enNext;
  assign w_load      = w_measuring && w_rise;
  assign w_ovfEvt    = w_measuring && !w_rise && w_sat;
  assign w_unused    = &{1'b0, bus.writedata[31:2]};

  // CTRL word as seen by software; CLR is a strobe and always reads 0.
  always_comb begin
    w_ctrlWord              = '0;
    w_ctrlWord[CTRL_EN_BIT] = r_en;
  end

  // Enable bit of CTRL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_en <= 1'b0;
    else       r_en <= w_enNext;
  end

  // Measurement FSM with the running period counter and high-time latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hcnt  <= '0;
    end else if (!w_enNext) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_WAIT_RISE;
        ST_WAIT_RISE: begin
          if (w_rise) begin
            r_cnt   <= CNT_ONE;
            r_hcnt  <= '0;
            r_state <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (w_rise) begin
            r_cnt  <= CNT_ONE;
            r_hcnt <= '0;
          end else if (w_sat) begin
            r_state <= ST_WAIT_RISE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
            if (w_fall) r_hcnt <= r_cnt;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Result registers and flags; later assignments win, so a load beats CLR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_period <= '0;
      r_high   <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_clr) begin
        r_period <= '0;
        r_high   <= '0;
        r_valid  <= 1'b0;
        r_ovf    <= 1'b0;
      end
      if (w_load) begin
        r_period <= r_cnt;
        r_high   <= r_hcnt;
        r_valid  <= 1'b1;
      end
      if (w_ovfEvt) r_ovf <= 1'b1;
    end
  end

  // Registered read data, presented the cycle after the read strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (w_rd) begin
      case (bus.address)
        ADDR_CTRL:   r_readdata <= w_ctrlWord;
        ADDR_STATUS: r_readdata <= statusWord(r_valid, r_ovf, w_level);
        ADDR_PERIOD: r_readdata <= 32'(r_period);
        ADDR_HIGH:   r_readdata <= 32'(r_high);
        default:     r_readdata <= '0;
      endcase
    end
  end

  assign bus.readdata = r_readdata;

endmodule

// File: tb/tb_avalon_pwm_capture.sv
// Bench for avalon_pwm_capture: drives PWM waveforms and bus accesses,
// predicts register contents from edge timestamps and checks every readback.
module tb_avalon_pwm_capture;
  import pwm_pkg::*;

  localparam int CNT_W  = 8;
  localparam int MAXCNT = (1 << CNT_W) - 1;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic pwm_in = 1'b0;

  avalon_pwm_capture_if bus();

  avalon_pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .pwm_in (pwm_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nTests = 0;
  int nFail  = 0;

  logic [31:0] expQ[$];
  logic [1:0]  addrQ[$];
  logic        rdPend = 1'b0;

  // Reference model: results derived from timestamps of driven edges.
  bit mEn, mArmed, mValid, mOvf, mLevel;
  int mPeriod, mHigh, mLastRise, mLastFall;

  function automatic void mUpdate();
    if (mEn && mArmed && (cyc - mLastRise) > MAXCNT) begin
      mOvf   = 1'b1;
      mArmed = 1'b0;
    end
  endfunction

  function automatic void mRise();
    mUpdate();
    mLevel = 1'b1;
    if (mEn) begin
      if (mArmed) begin
        mPeriod = cyc - mLastRise;
        mHigh   = mLastFall - mLastRise;
        mValid  = 1'b1;
      end
      mArmed    = 1'b1;
      mLastRise = cyc;
    end
  endfunction

  function automatic void mFall();
    mUpdate();
    mLevel    = 1'b0;
    mLastFall = cyc;
  endfunction

  function automatic void mClear();
    mUpdate();
    mValid  = 1'b0;
    mOvf    = 1'b0;
    mPeriod = 0;
    mHigh   = 0;
  endfunction

  function automatic void mReset();
    mEn = 0; mArmed = 0; mValid = 0; mOvf = 0;
    mPeriod = 0; mHigh = 0; mLevel = pwm_in;
  endfunction

  function automatic void mCtrlWrite(input logic [31:0] d);
    mUpdate();
    if (!d[CTRL_EN_BIT]) begin
      mEn    = 1'b0;
      mArmed = 1'b0;
    end else if (!mEn) begin
      mEn    = 1'b1;
      mArmed = 1'b0;
    end
    if (d[CTRL_CLR_BIT]) mClear();
  endfunction

  function automatic logic [31:0] expVal(input logic [1:0] a);
    logic [31:0] v;
    mUpdate();
    v = '0;
    case (a)
      ADDR_CTRL:   v[CTRL_EN_BIT] = mEn;
      ADDR_STATUS: begin
        v[STAT_VALID_BIT] = mValid;
        v[STAT_OVF_BIT]   = mOvf;
        v[STAT_LEVEL_BIT] = mLevel;
      end
      ADDR_PERIOD: v = 32'(mPeriod);
      default:     v = 32'(mHigh);
    endcase
    return v;
  endfunction

  function automatic string regName(input logic [1:0] a);
    case (a)
      ADDR_CTRL:   return "CTRL";
      ADDR_STATUS: return "STATUS";
      ADDR_PERIOD: return "PERIOD";
      default:     return "HIGH";
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h",
               name, cyc, got, exp);
    end
  endtask

  // Monitor: a read strobe sampled at a posedge yields readdata checked
  // at the following negedge against the oldest queued expectation.
  always @(posedge clk) rdPend <= bus.chipselect && !bus.read_n;

  always @(negedge clk) begin
    if (rdPend) begin
      if (expQ.size() == 0) begin
        nTests++;
        nFail++;
        $display("[TB] FAIL unexpected_read at cycle %0d: got 0x%08h, expected no data",
                 cyc, bus.readdata);
      end else begin
        checkOutput(regName(addrQ.pop_front()), bus.readdata, expQ.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic setPwm(input logic v);
    pwm_in = v;
    if (v) mRise();
    else   mFall();
  endtask

  task automatic busRead(input logic [1:0] a);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    expQ.push_back(expVal(a));
    addrQ.push_back(a);
    tick();
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
  endtask

  task automatic busWriteRaw(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    if (a == ADDR_CTRL) mCtrlWrite(d);
    busWriteRaw(a, d);
  endtask

  task automatic probeAll();
    for (int a = 0; a < 4; a++) busRead(2'(a));
  endtask

  // One PWM period: high h cycles then low l cycles; optionally reads
  // PERIOD and HIGH 4 and 5 cycles after the rise, without disturbing timing.
  task automatic applyStimulus(input int h, input int l, input bit chk);
    for (int t = 0; t < h + l; t++) begin
      if (t == 0) setPwm(1'b1);
      if (t == h) setPwm(1'b0);
      if (chk && t == 4)      busRead(ADDR_PERIOD);
      else if (chk && t == 5) busRead(ADDR_HIGH);
      else                    tick();
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    bus.read_n     = 1'b1;
    mReset();
    mLastRise = 0;
    mLastFall = 0;

    // Reset state
    repeat (3) tick();
    checkOutput("readdata_in_reset", bus.readdata, 32'h0);
    reset = 1'b0;
    repeat (2) tick();
    probeAll();

    // Enable, then steady 3/5 waveform
    busWrite(ADDR_CTRL, 32'h1);
    repeat (3) tick();
    probeAll();
    repeat (4) applyStimulus(3, 5, 1'b1);

    // Duty change to 6/2 mid-run
    repeat (3) applyStimulus(6, 2, 1'b1);
    repeat (4) tick();
    probeAll();

    // Randomized waveforms
    repeat (20) applyStimulus($urandom_range(2, 30), $urandom_range(4, 30),
                              1'($urandom_range(0, 1)));
    repeat (4) tick();
    probeAll();

    // Period exactly at saturation (rise wins), then one cycle beyond (OVF)
    applyStimulus(100, 155, 1'b1);
    applyStimulus(5, 5, 1'b1);
    applyStimulus(100, 156, 1'b1);
    applyStimulus(7, 5, 1'b1);
    applyStimulus(4, 4, 1'b1);
    repeat (4) tick();
    probeAll();

    // Constant-level input after a valid result
    busWrite(ADDR_CTRL, 32'h3);
    repeat (4) tick();
    probeAll();
    applyStimulus(5, 5, 1'b0);
    applyStimulus(6, 4, 1'b0);
    setPwm(1'b1);
    repeat (300) tick();
    probeAll();
    setPwm(1'b0);
    repeat (5) tick();
    applyStimulus(3, 3, 1'b1);
    applyStimulus(4, 4, 1'b1);

    // Disable mid-period, then re-enable
    applyStimulus(5, 5, 1'b0);
    setPwm(1'b1);
    repeat (5) tick();
    busWrite(ADDR_CTRL, 32'h0);
    repeat (3) tick();
    setPwm(1'b0);
    repeat (5) tick();
    probeAll();
    busWrite(ADDR_CTRL, 32'h1);
    repeat (3) tick();
    applyStimulus(4, 6, 1'b1);
    applyStimulus(5, 7, 1'b1);

    // CLR landing in the same cycle as rise_p: with two synchronizer
    // stages rise_p is seen two negedges after pwm_in is driven high.
    applyStimulus(4, 6, 1'b0);
    mClear();
    setPwm(1'b1);
    tick();
    tick();
    busWriteRaw(ADDR_CTRL, 32'h3);
    repeat (2) tick();
    setPwm(1'b0);
    repeat (6) tick();
    probeAll();

    // CLR on its own
    busWrite(ADDR_CTRL, 32'h3);
    repeat (2) tick();
    probeAll();

    // Reset in the middle of a measurement
    applyStimulus(5, 5, 1'b0);
    setPwm(1'b1);
    repeat (3) tick();
    setPwm(1'b0);
    repeat (2) tick();
    reset = 1'b1;
    mReset();
    repeat (2) tick();
    checkOutput("readdata_mid_reset", bus.readdata, 32'h0);
    reset = 1'b0;
    repeat (3) tick();
    probeAll();

    repeat (5) tick();
    checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
